// File: rtl/led_pwm_fader.sv
// led_pwm_fader: four 8-bit PWM LED channels whose levels are set over a valid/ready
// command port and applied only at PWM period boundaries. Build macro LED_PWM_FADE_EN
// enables a per-period one-step fade toward each target; undefined means levels jump.
module led_pwm_fader #(
  parameter int unsigned PRESCALE = 98
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_led,
  input  logic [7:0] cmd_level,
  output logic [3:0] led,
  output logic       busy
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [1:0]    hold_led_q, hold_led_d;
  logic [7:0]    hold_level_q, hold_level_d;
  logic [7:0]    target_q [4];
  logic [7:0]    target_d [4];
  logic [7:0]    cur_q [4];
  logic [7:0]    cur_d [4];
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          tick, boundary;

  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    boundary  = tick && (pwm_cnt_q == 8'hff);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is low while a command waits for its boundary, and the sender must hold
  // cmd_valid and its payload stable until the transfer edge.
  always_comb begin
    state_d      = state_q;
    hold_led_d   = hold_led_q;
    hold_level_d = hold_level_q;
    cmd_ready    = 1'b0;
    for (int i = 0; i < 4; i++) target_d[i] = target_q[i];
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          hold_led_d   = cmd_led;
          hold_level_d = cmd_level;
          state_d      = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (boundary) begin
          target_d[hold_led_q] = hold_level_q;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cur follows the pre-write targets, so a freshly written target shows one period later.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cur_d[i] = cur_q[i];
      if (boundary) begin
`ifdef LED_PWM_FADE_EN
        if (cur_q[i] < target_q[i]) cur_d[i] = cur_q[i] + 8'd1;
        else if (cur_q[i] > target_q[i]) cur_d[i] = cur_q[i] - 8'd1;
`else
        cur_d[i] = target_q[i];
`endif
      end
      led_d[i] = (pwm_cnt_q < cur_q[i]);
    end
  end

  always_comb begin
    busy_d = (state_q == ST_PENDING);
    for (int i = 0; i < 4; i++) begin
      if (cur_q[i] != target_q[i]) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      hold_led_q   <= '0;
      hold_level_q <= '0;
      led_q        <= '0;
      busy_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        target_q[i] <= '0;
        cur_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      hold_led_q   <= hold_led_d;
      hold_level_q <= hold_level_d;
      led_q        <= led_d;
      busy_q       <= busy_d;
      for (int i = 0; i < 4; i++) begin
        target_q[i] <= target_d[i];
        cur_q[i]    <= cur_d[i];
      end
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader at PRESCALE=2 (512-cycle PWM period): command table with
// hand-computed ready-drop and duty counts, plus handshake, collision, reset and fade sequences.
module tb_led_pwm_fader;
  localparam int PRE    = 2;
  localparam int PERIOD = 256 * PRE;

  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_led   = 2'd0;
  logic [7:0] cmd_level = 8'd0;
  logic       cmd_ready;
  logic [3:0] led;
  logic       busy;

  int cyc;
  int checks = 0;
  int errors = 0;
  int duty [4];
  int model [4];

  typedef struct {
    int         offs;      // cycle within the period at which the command is offered
    logic [1:0] idx;
    logic [7:0] level;
    int         exp_drop;  // cycles cmd_ready stays low after the accept edge
    int         exp_duty;  // high cycles per period on the commanded LED
  } vec_t;
  vec_t vecs [6];

  led_pwm_fader #(.PRESCALE(PRE)) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_led   (cmd_led),
    .cmd_level (cmd_level),
    .led       (led),
    .busy      (busy)
  );

  // clock/reset block
  always #5 clk_25mhz = ~clk_25mhz;

  // cyc = index of the next rising edge counted from reset release
  always @(posedge clk_25mhz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic align(input int offs);
    while (cyc % PERIOD != offs) @(negedge clk_25mhz);
  endtask

  // Offers a command at a negedge; returns the index of the edge that accepted it.
  task automatic send(input logic [1:0] l, input logic [7:0] v, output int acc);
    int n;
    cmd_valid = 1'b1;
    cmd_led   = l;
    cmd_level = v;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clk_25mhz);
      n++;
    end
    if (n >= 3000) check("send_timeout", 32'(n), 32'd0);
    acc = cyc;
    @(negedge clk_25mhz);
  endtask

  task automatic count_drop(output int cnt);
    cnt = 0;
    while (cmd_ready !== 1'b1 && cnt < 3000) begin
      cnt++;
      if (cnt == 2) check("busy_pending", 32'(busy), 32'd1);
      @(negedge clk_25mhz);
    end
  endtask

  task automatic measure();
    for (int i = 0; i < 4; i++) duty[i] = 0;
    repeat (PERIOD) begin
      for (int i = 0; i < 4; i++) if (led[i] === 1'b1) duty[i]++;
      @(negedge clk_25mhz);
    end
  endtask

  task automatic check_duties(input string name);
    measure();
    for (int i = 0; i < 4; i++) check($sformatf("%s_duty%0d", name, i), 32'(duty[i]), 32'(2 * model[i]));
  endtask

  task automatic run_cmd(input vec_t v, input string name);
    int acc, drop;
    align(v.offs);
    send(v.idx, v.level, acc);
    cmd_valid = 1'b0;
    count_drop(drop);
    check({name, "_drop"}, 32'(drop), 32'(v.exp_drop));
    repeat (PERIOD + 8) @(negedge clk_25mhz);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
    model[v.idx] = v.level;
    measure();
    check({name, "_own_duty"}, 32'(duty[v.idx]), 32'(v.exp_duty));
    for (int i = 0; i < 4; i++) check($sformatf("%s_duty%0d", name, i), 32'(duty[i]), 32'(2 * model[i]));
  endtask

  initial begin
    int acc [4];
    int a, drop, b;
    vec_t v;

    vecs[0] = '{offs: 5,   idx: 2'd1, level: 8'd64,  exp_drop: 506, exp_duty: 128};
    vecs[1] = '{offs: 100, idx: 2'd0, level: 8'd255, exp_drop: 411, exp_duty: 510};
    vecs[2] = '{offs: 300, idx: 2'd2, level: 8'd0,   exp_drop: 211, exp_duty: 0};
    vecs[3] = '{offs: 510, idx: 2'd1, level: 8'd64,  exp_drop: 1,   exp_duty: 128};
    vecs[4] = '{offs: 511, idx: 2'd3, level: 8'd1,   exp_drop: 512, exp_duty: 2};
    vecs[5] = '{offs: 0,   idx: 2'd0, level: 8'd0,   exp_drop: 511, exp_duty: 0};
    for (int i = 0; i < 4; i++) model[i] = 0;

    repeat (3) @(negedge clk_25mhz);
    check("rst_led", 32'(led), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

`ifdef LED_PWM_FADE_EN
    align(5);
    send(2'd2, 8'd5, a);
    cmd_valid = 1'b0;
    count_drop(drop);
    b = a + drop;
    for (int k = 1; k <= 5; k++) begin
      while (cyc < b + PERIOD * k + 1) @(negedge clk_25mhz);
      check($sformatf("fade_step%0d", k), 32'(dut.cur_q[2]), 32'(k));
    end
    check("fade_busy_last", 32'(busy), 32'd1);
    @(negedge clk_25mhz);
    check("fade_busy_done", 32'(busy), 32'd0);

    reset = 1'b1;
    @(negedge clk_25mhz);
    reset = 1'b0;
    align(5);
    send(2'd2, 8'd5, a);
    cmd_valid = 1'b0;
    count_drop(drop);
    b = a + drop;
    while (cyc < b + PERIOD * 3 + 1) @(negedge clk_25mhz);
    check("fade_mid_cur", 32'(dut.cur_q[2]), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("fade_rst_cur", 32'(dut.cur_q[2]), 32'd0);
    check("fade_rst_busy", 32'(busy), 32'd0);
    check("fade_rst_led", 32'(led), 32'd0);
    @(negedge clk_25mhz);
    reset = 1'b0;
`else
    for (int i = 0; i < 6; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Four back-to-back commands with cmd_valid held: one accept per boundary.
    align(50);
    for (int i = 0; i < 4; i++) send(2'(i), 8'(10 * (i + 1)), acc[i]);
    cmd_valid = 1'b0;
    check("hs_gap01", 32'(acc[1] - acc[0]), 32'd462);
    check("hs_gap12", 32'(acc[2] - acc[1]), 32'd512);
    check("hs_gap23", 32'(acc[3] - acc[2]), 32'd512);
    count_drop(drop);
    check("hs_last_drop", 32'(drop), 32'd511);
    for (int i = 0; i < 4; i++) model[i] = 10 * (i + 1);
    repeat (PERIOD + 8) @(negedge clk_25mhz);
    check_duties("hs");

    // Accept on the boundary edge itself: old level must persist for a full extra period.
    align(511);
    send(2'd3, 8'd100, a);
    cmd_valid = 1'b0;
    count_drop(drop);
    check("col_drop", 32'(drop), 32'd512);
    @(negedge clk_25mhz);
    check_duties("col_old");
    repeat (4) @(negedge clk_25mhz);
    model[3] = 100;
    check_duties("col_new");

    // Reset mid-pending: everything clears on the spot and the pending command is lost.
    align(200);
    send(2'd2, 8'd50, a);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk_25mhz);
    check("mr_ready_before", 32'(cmd_ready), 32'd0);
    check("mr_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mr_led", 32'(led), 32'd0);
    check("mr_ready", 32'(cmd_ready), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    @(negedge clk_25mhz);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 0;
    v = '{offs: 5, idx: 2'd1, level: 8'd64, exp_drop: 506, exp_duty: 128};
    run_cmd(v, "post_rst");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
